// File: rtl/tetris_board_render_if.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_board_render_if
//  Description : Back-buffer cell write port and front/back swap handshake
//                of the Tetris board renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tetris_board_render_if;
    logic       wr_en;
    logic [3:0] wr_x;
    logic [4:0] wr_y;
    logic [2:0] wr_color;
    logic       wr_ready;
    logic       swap_req;
    logic       swap_ack;

    // Game logic side: issues cell writes and swap requests
    modport master (
        output wr_en, wr_x, wr_y, wr_color, swap_req,
        input  wr_ready, swap_ack
    );

    // Renderer side: accepts writes, acknowledges swaps
    modport slave (
        input  wr_en, wr_x, wr_y, wr_color, swap_req,
        output wr_ready, swap_ack
    );
endinterface
`default_nettype wire

// File: rtl/tetris_board_render.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_board_render
//  Description : Double-buffered 10x20 Tetris board renderer. Maps the sync
//                generator pixel position to a board cell, looks up its
//                colour code in the front buffer and drives r/g/b with a
//                fixed 2-cycle latency. Front/back swap happens only on a
//                vsync rising edge so the displayed frame never tears.
//                Optional macro TETRIS_GRID_LINES_EN draws 404040 lines on
//                the last column/row of every cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module tetris_board_render #(
    parameter int unsigned X0     = 240,
    parameter int unsigned Y0     = 80,
    parameter logic [23:0] BG_RGB = 24'h202020
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic [8:0] row,
    input  wire logic [9:0] column,
    input  wire logic       blank_n,
    input  wire logic       hsync,
    input  wire logic       vsync,
    tetris_board_render_if.slave bus,
    output logic      [7:0] r,
    output logic      [7:0] g,
    output logic      [7:0] b,
    output logic            blank_n_o,
    output logic            hsync_o,
    output logic            vsync_o
);

    localparam logic [9:0]  c_x_lo     = 10'(X0);
    localparam logic [9:0]  c_x_hi     = 10'(X0 + 160);
    localparam logic [8:0]  c_y_lo     = 9'(Y0);
    localparam logic [8:0]  c_y_hi     = 9'(Y0 + 320);
    localparam logic [23:0] c_grid_rgb = 24'h404040;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   front_q, front_d;
    logic   swap_ack_q, swap_ack_d;
    logic   vsync_prev_q, vsync_prev_d;
    logic   vsync_rise;

    // [buffer][cell index = y*10 + x] -> colour code
    logic [1:0][199:0][2:0] buf_q, buf_d;
    logic [7:0]             wr_idx;
    logic [7:0]             rd_idx;
    logic                   wr_ok;

    // Stage 1: cell coordinates, in-board flag, grid flag, timing
    logic [3:0] cx_q, cx_d;
    logic [4:0] cy_q, cy_d;
    logic       inb_q, inb_d;
    logic       grid_q, grid_d;
    logic [2:0] tim1_q, tim1_d;     // {blank_n, hsync, vsync}

    // Stage 2: pixel colour and timing
    logic [23:0] rgb_q, rgb_d;
    logic [2:0]  tim2_q, tim2_d;

    function automatic logic [23:0] palette(input logic [2:0] code);
        case (code)
            3'd0:    palette = 24'h000000;
            3'd1:    palette = 24'h00FFFF;
            3'd2:    palette = 24'hFFFF00;
            3'd3:    palette = 24'hFF00FF;
            3'd4:    palette = 24'h00FF00;
            3'd5:    palette = 24'hFF0000;
            3'd6:    palette = 24'h0000FF;
            default: palette = 24'hFF8000;
        endcase
    endfunction

    // Stage 1: locate the pixel on the board
    always_comb begin
        inb_d  = (column >= c_x_lo) && (column < c_x_hi) &&
                 (row >= c_y_lo) && (row < c_y_hi);
        cx_d   = inb_d ? 4'((column - c_x_lo) >> 4) : 4'd0;
        cy_d   = inb_d ? 5'((row - c_y_lo) >> 4) : 5'd0;
`ifdef TETRIS_GRID_LINES_EN
        grid_d = inb_d && ((4'(column - c_x_lo) == 4'hF) ||
                           (4'(row - c_y_lo) == 4'hF));
`else
        grid_d = 1'b0;
`endif
        tim1_d = {blank_n, hsync, vsync};
    end

    // Stage 2: colour lookup in the front buffer, blanking and background
    always_comb begin
        rd_idx = {3'b000, cy_q} * 8'd10 + {4'b0000, cx_q};
        tim2_d = tim1_q;
        if (!tim1_q[2]) begin
            rgb_d = 24'h000000;
        end else if (!inb_q) begin
            rgb_d = BG_RGB;
        end else if (grid_q) begin
            rgb_d = c_grid_rgb;
        end else begin
            rgb_d = palette(buf_q[front_q][rd_idx]);
        end
    end

    // Back-buffer write: only in-range cells while no swap is pending
    always_comb begin
        buf_d  = buf_q;
        wr_idx = {3'b000, bus.wr_y} * 8'd10 + {4'b0000, bus.wr_x};
        wr_ok  = bus.wr_en && (state_q == IDLE) &&
                 (bus.wr_x < 4'd10) && (bus.wr_y < 5'd20);
        if (wr_ok) begin
            buf_d[~front_q][wr_idx] = bus.wr_color;
        end
    end

    // Swap FSM: a request waits for the next vsync rising edge
    always_comb begin
        vsync_prev_d = vsync;
        vsync_rise   = vsync && !vsync_prev_q;
        state_d      = state_q;
        front_d      = front_q;
        swap_ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.swap_req) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (vsync_rise) begin
                    front_d    = ~front_q;
                    swap_ack_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            front_q      <= 1'b0;
            swap_ack_q   <= 1'b0;
            vsync_prev_q <= 1'b0;
            buf_q        <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            inb_q        <= 1'b0;
            grid_q       <= 1'b0;
            tim1_q       <= '0;
            rgb_q        <= '0;
            tim2_q       <= '0;
        end else begin
            state_q      <= state_d;
            front_q      <= front_d;
            swap_ack_q   <= swap_ack_d;
            vsync_prev_q <= vsync_prev_d;
            buf_q        <= buf_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            inb_q        <= inb_d;
            grid_q       <= grid_d;
            tim1_q       <= tim1_d;
            rgb_q        <= rgb_d;
            tim2_q       <= tim2_d;
        end
    end

    assign bus.wr_ready = (state_q == IDLE);
    assign bus.swap_ack = swap_ack_q;
    assign r            = rgb_q[23:16];
    assign g            = rgb_q[15:8];
    assign b            = rgb_q[7:0];
    assign blank_n_o    = tim2_q[2];
    assign hsync_o      = tim2_q[1];
    assign vsync_o      = tim2_q[0];

endmodule
`default_nettype wire

// File: tb/tb_tetris_board_render.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tetris_board_render
//  Description : Directed self-checking bench for tetris_board_render with a
//                reference board model and an expected-pixel queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tetris_board_render;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] row = '0;
    logic [9:0] column = '0;
    logic       blank_n = 1'b0;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic [7:0] r, g, b;
    logic       blank_n_o, hsync_o, vsync_o;

    always #5 clk = ~clk;

    tetris_board_render_if bus ();

    tetris_board_render dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .column    (column),
        .blank_n   (blank_n),
        .hsync     (hsync),
        .vsync     (vsync),
        .bus       (bus.slave),
        .r         (r),
        .g         (g),
        .b         (b),
        .blank_n_o (blank_n_o),
        .hsync_o   (hsync_o),
        .vsync_o   (vsync_o)
    );

    typedef struct {
        logic [23:0] rgb;
        logic [2:0]  tim;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    // Reference board state
    logic [2:0] m_buf [2][200];
    bit         m_front, m_pend, m_vprev, exp_ack;

    // Write/swap request values applied on the next step
    logic       g_we = 1'b0;
    logic [3:0] g_wx = '0;
    logic [4:0] g_wy = '0;
    logic [2:0] g_wc = '0;
    logic       g_sr = 1'b0;

    function automatic logic [23:0] pal(input logic [2:0] c);
        logic [23:0] t [8];
        t = '{24'h000000, 24'h00FFFF, 24'hFFFF00, 24'hFF00FF,
              24'h00FF00, 24'hFF0000, 24'h0000FF, 24'hFF8000};
        return t[c];
    endfunction

    function automatic logic [23:0] exp_pix(input int rw, input int cl, input logic bl);
        int cx, cy;
        if (!bl) return 24'h000000;
        if (cl < 240 || cl >= 400 || rw < 80 || rw >= 400) return 24'h202020;
`ifdef TETRIS_GRID_LINES_EN
        if ((cl - 240) % 16 == 15 || (rw - 80) % 16 == 15) return 24'h404040;
`endif
        cx = (cl - 240) / 16;
        cy = (rw - 80) / 16;
        return pal(m_buf[int'(m_front)][cy * 10 + cx]);
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 200; i++) begin
            m_buf[0][i] = 3'd0;
            m_buf[1][i] = 3'd0;
        end
        m_front = 1'b0;
        m_pend  = 1'b0;
        m_vprev = 1'b0;
        exp_ack = 1'b0;
        q.delete();
    endtask

    // One clock of stimulus: check what is due, drive, predict
    task automatic step(input int rw, input int cl, input logic bl,
                        input logic hs, input logic vs);
        exp_t e;
        bit   rise;
        @(negedge clk);
        if (q.size() == 2) begin
            e = q.pop_front();
            chk("rgb", {r, g, b}, e.rgb);
            chk("sync", {21'd0, blank_n_o, hsync_o, vsync_o}, {21'd0, e.tim});
        end
        chk("swap_ack", {23'd0, bus.swap_ack}, {23'd0, exp_ack});
        chk("wr_ready", {23'd0, bus.wr_ready}, {23'd0, !m_pend});
        row          = 9'(rw);
        column       = 10'(cl);
        blank_n      = bl;
        hsync        = hs;
        vsync        = vs;
        bus.wr_en    = g_we;
        bus.wr_x     = g_wx;
        bus.wr_y     = g_wy;
        bus.wr_color = g_wc;
        bus.swap_req = g_sr;
        e.rgb = exp_pix(rw, cl, bl);
        e.tim = {bl, hs, vs};
        q.push_back(e);
        rise    = vs && !m_vprev;
        m_vprev = vs;
        if (!m_pend && g_we && g_wx < 10 && g_wy < 20)
            m_buf[int'(!m_front)][int'(g_wy) * 10 + int'(g_wx)] = g_wc;
        exp_ack = 1'b0;
        if (m_pend && rise) begin
            m_front = !m_front;
            m_pend  = 1'b0;
            exp_ack = 1'b1;
        end else if (!m_pend && g_sr) begin
            m_pend = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pix(input int rw, input int cl);
        step(rw, cl, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic vs_pulse();
        for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b1, 1'b1);
        idle(2);
    endtask

    task automatic wr(input int x, input int y, input int c);
        g_we = 1'b1;
        g_wx = 4'(x);
        g_wy = 5'(y);
        g_wc = 3'(c);
        idle(1);
        g_we = 1'b0;
    endtask

    task automatic swap();
        g_sr = 1'b1;
        idle(1);
        g_sr = 1'b0;
    endtask

    task automatic probe_cell(input int cx, input int cy);
        pix(80 + 16 * cy, 240 + 16 * cx);
        pix(80 + 16 * cy + 3, 240 + 16 * cx + 8);
        pix(80 + 16 * cy + 15, 240 + 16 * cx + 15);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        {blank_n, hsync, vsync} = 3'b000;
        bus.wr_en = 1'b0;
        bus.swap_req = 1'b0;
        g_we = 1'b0;
        g_sr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rgb", {r, g, b}, 24'h000000);
        chk("rst_sync", {21'd0, blank_n_o, hsync_o, vsync_o}, 24'd0);
        chk("rst_ack", {23'd0, bus.swap_ack}, 24'd0);
        chk("rst_ready", {23'd0, bus.wr_ready}, 24'd1);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_x = '0; bus.wr_y = '0;
        bus.wr_color = '0; bus.swap_req = 1'b0;
        model_reset();

        // Reset, then an empty frame: black board, grey outside, blanking
        reset_dut();
        vs_pulse();
        pix(80, 240);  pix(399, 399); pix(200, 300);
        pix(80, 239);  pix(80, 400);  pix(79, 240); pix(400, 240); pix(10, 10);
        step(200, 300, 1'b0, 1'b1, 1'b0);
        step(10, 10, 1'b0, 1'b0, 1'b0);

        // Palette row plus cell (3,5)=5, swapped in at the next vsync rise
        for (int i = 0; i < 8; i++) wr(i, 0, i);
        wr(3, 5, 5);
        swap();
        idle(2);
        vs_pulse();
        for (int i = 0; i < 8; i++) probe_cell(i, 0);
        pix(160, 288); pix(175, 303); pix(168, 295);
        pix(160, 287); pix(160, 304); pix(159, 288); pix(176, 288);

        // Out-of-range writes are dropped, then swap back to the empty buffer
        wr(10, 0, 3); wr(0, 20, 3); wr(15, 31, 7);
        swap();
        vs_pulse();
        probe_cell(0, 1); probe_cell(0, 0); probe_cell(3, 5); probe_cell(9, 19);

        // Request held and repeated while pending; write dropped; one ack
        g_sr = 1'b1;
        idle(3);
        wr(0, 0, 2);
        g_sr = 1'b0;
        idle(1);
        swap();
        vs_pulse();
        vs_pulse();
        probe_cell(0, 0); probe_cell(3, 5);

        // Request on the vsync rising-edge cycle swaps only one frame later
        g_sr = 1'b1;
        vs_pulse();
        g_sr = 1'b0;
        probe_cell(3, 5);
        vs_pulse();
        probe_cell(3, 5); probe_cell(2, 0);

        // Reset while pending discards the swap and clears both buffers
        wr(1, 1, 6);
        swap();
        idle(1);
        reset_dut();
        vs_pulse();
        probe_cell(1, 1);
        swap();
        vs_pulse();
        probe_cell(1, 1); probe_cell(3, 5); probe_cell(7, 0);

        // Cell (0,0) code 4: fill colour and cell-edge pixel
        wr(0, 0, 4);
        swap();
        vs_pulse();
        pix(80, 240); pix(80, 255); pix(95, 240); pix(90, 250);

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
